// File: rtl/simon_key_sched.sv
// rtl/simon_key_sched.sv - Simon 128/128 key schedule, one round key per valid/ready handshake
// Holds only two key words and expands the next word on each accepted transfer.
module simon_key_sched #(
  parameter int N = 64,
  parameter int T = 68
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [2*N-1:0] k0_i,
  output logic [N-1:0]   rk_o,
  output logic [6:0]     rk_idx_o,
  output logic           rk_valid_o,
  input  logic           rk_ready_i,
  output logic           busy_o,
  output logic           done_o
);

  localparam logic [N-1:0] C    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [61:0]  Z2   = 62'b10101111011100000011010010011000101000010001111110010110110011;
  localparam logic [6:0]   LAST = 7'(T - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state_q;
  logic [N-1:0] ka_q, kb_q;
  logic [6:0]   idx_q;
  logic [5:0]   zp_q;
  logic         done_q;

  logic [N-1:0] rot3, mix, kb_d;
  logic         z_bit;

  // z2[0] is the leftmost character, i.e. the MSB of the literal.
  always_comb begin
    z_bit = Z2[6'd61 - zp_q];
    rot3  = {kb_q[2:0], kb_q[N-1:3]};
    mix   = rot3 ^ {rot3[0], rot3[N-1:1]};
    kb_d  = ka_q ^ mix ^ C ^ {{(N-1){1'b0}}, z_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ka_q    <= '0;
      kb_q    <= '0;
      idx_q   <= '0;
      zp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            ka_q    <= k0_i[N-1:0];
            kb_q    <= k0_i[2*N-1:N];
            idx_q   <= '0;
            zp_q    <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (rk_ready_i) begin
            if (idx_q == LAST) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              ka_q  <= kb_q;
              kb_q  <= kb_d;
              idx_q <= idx_q + 7'd1;
              zp_q  <= (zp_q == 6'd61) ? 6'd0 : zp_q + 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rk_o       = ka_q;
  assign rk_idx_o   = idx_q;
  assign rk_valid_o = (state_q == RUN);
  assign busy_o     = (state_q == RUN);
  assign done_o     = done_q;

endmodule

// File: tb/tb_simon_key_sched.sv
// tb/tb_simon_key_sched.sv - directed bench for simon_key_sched
// Reference keys come from the textbook Simon key-expansion form.
module tb_simon_key_sched;

  localparam logic [127:0] KEY  = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KEY2 = 128'h1918111009080100_0123456789abcdef;

  logic         clk = 1'b0;
  logic         rst, start_i, rk_ready_i;
  logic [127:0] k0_i;
  logic [63:0]  rk_o;
  logic [6:0]   rk_idx_o;
  logic         rk_valid_o, busy_o, done_o;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [63:0] exp_k [0:67];
  logic [63:0] cap   [0:67];

  always #5 clk = ~clk;

  simon_key_sched #(.N(64), .T(68)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .k0_i       (k0_i),
    .rk_o       (rk_o),
    .rk_idx_o   (rk_idx_o),
    .rk_valid_o (rk_valid_o),
    .rk_ready_i (rk_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void gen(input logic [127:0] key);
    string       z = "10101111011100000011010010011000101000010001111110010110110011";
    logic [63:0] t;
    exp_k[0] = key[63:0];
    exp_k[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      t = (exp_k[i+1] >> 3) | (exp_k[i+1] << 61);
      t = t ^ ((t >> 1) | (t << 63));
      exp_k[i+2] = ~exp_k[i] ^ t ^ 64'd3 ^ ((z[i % 62] == "1") ? 64'd1 : 64'd0);
    end
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_rk"},    rk_o,       64'd0);
    check({tag, "_idx"},   rk_idx_o,   64'd0);
    check({tag, "_valid"}, rk_valid_o, 64'd0);
    check({tag, "_busy"},  busy_o,     64'd0);
    check({tag, "_done"},  done_o,     64'd0);
  endtask

  // intr_idx >= 0 pulses start_i with another key while that index is shown;
  // chain returns in the done cycle so the caller can start back-to-back.
  task automatic run(input logic [127:0] key, input bit bp, input int intr_idx, input bit chain);
    int cnt = 0;
    int cyc = 0;
    bit rdy;
    gen(key);
    start_i = 1'b1;
    k0_i    = key;
    step();
    start_i = 1'b0;
    k0_i    = ~key;
    while (cnt < 68 && cyc < 1000) begin
      check($sformatf("valid[%0d]", cnt), rk_valid_o, 64'd1);
      check($sformatf("busy[%0d]", cnt),  busy_o,     64'd1);
      check($sformatf("idx[%0d]", cnt),   rk_idx_o,   64'(cnt));
      check($sformatf("rk[%0d]", cnt),    rk_o,       exp_k[cnt]);
      check($sformatf("done[%0d]", cnt),  done_o,     64'd0);
      cap[cnt] = rk_o;
      if (cnt == intr_idx) begin
        start_i = 1'b1;
        k0_i    = ~key;
      end
      rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      rk_ready_i = rdy;
      step();
      cyc++;
      start_i = 1'b0;
      if (rdy) cnt++;
    end
    if (cnt < 68) check("run_timeout", 64'(cnt), 64'd68);
    rk_ready_i = 1'b0;
    check("done_pulse",  done_o,     64'd1);
    check("done_valid",  rk_valid_o, 64'd0);
    check("done_busy",   busy_o,     64'd0);
    if (!bp) check("done_cycle", 64'(cyc + 1), 64'd69);
    if (!chain) begin
      step();
      check("post_done",  done_o,     64'd0);
      check("post_valid", rk_valid_o, 64'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    rk_ready_i = 1'b0;
    k0_i       = '0;
    step();
    start_i = 1'b1;
    k0_i    = KEY;
    step();
    rst     = 1'b0;
    start_i = 1'b0;
    check_idle("reset");
    step();
    check("idle_hold_valid", rk_valid_o, 64'd0);

    run(KEY, 1'b0, -1, 1'b0);
    check("k0_literal", cap[0], 64'h0706050403020100);
    check("k1_literal", cap[1], 64'h0f0e0d0c0b0a0908);
    check("k2_literal", cap[2], 64'h79E8DB8ABD2C1F4C);

    run(KEY, 1'b1, -1, 1'b0);
    run({128{1'b1}}, 1'b0, -1, 1'b0);
    run(128'd0, 1'b0, -1, 1'b0);
    run(KEY, 1'b0, 10, 1'b0);
    run(KEY, 1'b0, 67, 1'b0);

    start_i = 1'b1;
    k0_i    = KEY;
    step();
    start_i    = 1'b0;
    rk_ready_i = 1'b1;
    repeat (30) step();
    check("pre_reset_idx", rk_idx_o, 64'd30);
    rst = 1'b1;
    step();
    rst        = 1'b0;
    rk_ready_i = 1'b0;
    check_idle("midrun_reset");
    step();
    check("midrun_idle_valid", rk_valid_o, 64'd0);

    run(KEY2, 1'b0, -1, 1'b1);
    run(KEY, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
